dmem_arbiter: RTL and testbench

Arbiter and sequencer for the single-port data memory behind the MEM stage. Shares one memory access per cycle between the pipeline MEM stage (CPU port) and a loader/DMA port used for program-data preload and debug readback. The CPU port has fixed priority, with a starvation guard for the DMA port. Read data returns one cycle after grant, tagged to its owner; the CPU is stalled while denied.

---
 rtl/dmem_pkg.sv | 14 +
 rtl/dmem_starve_ctr.sv | 22 ++
 rtl/dmem_arbiter.sv | 102 ++++++++++
 tb/tb_dmem_arbiter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and widths for the data-memory arbiter.
// Read-owner encoding tags which port the in-flight read response belongs to.
package dmem_pkg;

  localparam int DMEM_ADDR_W = 7;
  localparam int DMEM_DATA_W = 32;

  typedef enum logic [1:0] {
    NONE   = 2'd0,
    CPU_RD = 2'd1,
    DMA_RD = 2'd2
  } rd_owner_e;

endpackage

// File: rtl/dmem_starve_ctr.sv
// Saturating 4-bit counter of consecutive cycles the DMA port has been denied.
// A clear takes precedence over an increment.
module dmem_starve_ctr #(
  parameter int LIM = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] cnt
);

  localparam logic [3:0] LIM4 = 4'(LIM);

  always_ff @(posedge clk) begin
    if (reset || clr)
      cnt <= '0;
    else if (inc && (cnt != LIM4))
      cnt <= cnt + 4'd1;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter: CPU has fixed priority, DMA gets a forced
// grant after STARVE_LIM denied cycles. Read data returns one cycle after grant.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W     = DMEM_ADDR_W,
  parameter int DATA_W     = DMEM_DATA_W,
  parameter int STARVE_LIM = 4
) (
  input  logic              clk,
  input  logic              reset,
  // CPU / MEM stage
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_stall,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  // DMA / loader
  input  logic              dma_valid,
  output logic              dma_ready,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_rvalid,
  // memory
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [3:0] LIM4 = 4'(STARVE_LIM);

  logic        cpu_grant, dma_grant, force_dma;
  logic [3:0]  starve_cnt;
  rd_owner_e   state_q, state_d;
  logic [DATA_W-1:0] cpu_hold_q, dma_hold_q;

  // Grant decision is purely combinational: zero added latency.
  always_comb begin
    force_dma = dma_valid && (starve_cnt == LIM4);
    dma_grant = force_dma || (dma_valid && !cpu_req);
    cpu_grant = cpu_req && !dma_grant;
  end

  assign cpu_stall = cpu_req && !cpu_grant;
  assign dma_ready = dma_grant;

  always_comb begin
    mem_en    = (cpu_grant || dma_grant) && !reset;
    mem_we    = dma_grant ? dma_we    : cpu_we;
    mem_addr  = dma_grant ? dma_addr  : cpu_addr;
    mem_wdata = dma_grant ? dma_wdata : cpu_wdata;
  end

  dmem_starve_ctr #(.LIM(STARVE_LIM)) u_starve (
    .clk   (clk),
    .reset (reset),
    .clr   (dma_grant || !dma_valid),
    .inc   (dma_valid && !dma_grant),
    .cnt   (starve_cnt)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= NONE;
    else       state_q <= state_d;
  end

  // Responses are gated by reset so a read in flight at reset is dropped.
  always_comb begin
    state_d    = NONE;
    cpu_rvalid = 1'b0;
    dma_rvalid = 1'b0;
    if (cpu_grant && !cpu_we)      state_d = CPU_RD;
    else if (dma_grant && !dma_we) state_d = DMA_RD;
    case (state_q)
      CPU_RD:  cpu_rvalid = !reset;
      DMA_RD:  dma_rvalid = !reset;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_hold_q <= '0;
      dma_hold_q <= '0;
    end else begin
      if (cpu_rvalid) cpu_hold_q <= mem_rdata;
      if (dma_rvalid) dma_hold_q <= mem_rdata;
    end
  end

  // The memory output is already registered; pass it through during the
  // response cycle and hold the captured copy afterwards.
  assign cpu_rdata = cpu_rvalid ? mem_rdata : cpu_hold_q;
  assign dma_rdata = dma_rvalid ? mem_rdata : dma_hold_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: external memory model, grant model
// and a queue of expected read responses checked when they come due.
module tb_dmem_arbiter;
  import dmem_pkg::*;

  localparam int AW = 7;
  localparam int DW = 32;
  localparam int LIM = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_req, cpu_we, cpu_stall, cpu_rvalid;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          dma_valid, dma_ready, dma_we, dma_rvalid;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata, dma_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIM(LIM)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .dma_valid(dma_valid), .dma_ready(dma_ready), .dma_we(dma_we), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // external synchronous memory
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  typedef struct {
    int            own;   // 1 = CPU, 2 = DMA
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t          q[$];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            ms = 0;
  logic [DW-1:0] last_cpu = '0, last_dma = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_resp();
    exp_t e;
    chk("rv_both", {63'd0, cpu_rvalid & dma_rvalid}, 64'd0);
    if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      chk("cpu_rv", {63'd0, cpu_rvalid}, {63'd0, e.own == 1});
      chk("dma_rv", {63'd0, dma_rvalid}, {63'd0, e.own == 2});
      if (e.own == 1) begin chk("cpu_rdata", {32'd0, cpu_rdata}, {32'd0, e.data}); last_cpu = e.data; end
      else            begin chk("dma_rdata", {32'd0, dma_rdata}, {32'd0, e.data}); last_dma = e.data; end
    end else begin
      chk("cpu_rv_idle", {63'd0, cpu_rvalid}, 64'd0);
      chk("dma_rv_idle", {63'd0, dma_rvalid}, 64'd0);
      chk("cpu_hold", {32'd0, cpu_rdata}, {32'd0, last_cpu});
      chk("dma_hold", {32'd0, dma_rdata}, {32'd0, last_dma});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    check_resp();
  endtask

  // Drive one cycle, check grant/strobe against the model, queue expected reads.
  task automatic drive(input logic cr, input logic cw, input logic [AW-1:0] ca, input logic [DW-1:0] cd,
                       input logic dv, input logic dw, input logic [AW-1:0] da, input logic [DW-1:0] dd,
                       output logic ready_obs);
    logic fd, dg, cg;
    exp_t e;
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    dma_valid = dv; dma_we = dw; dma_addr = da; dma_wdata = dd;
    #1;
    fd = dv && (ms == LIM);
    dg = fd || (dv && !cr);
    cg = cr && !dg;
    ready_obs = dma_ready;
    chk("cpu_stall", {63'd0, cpu_stall}, {63'd0, cr && !cg});
    chk("dma_ready", {63'd0, dma_ready}, {63'd0, dg});
    chk("mem_en", {63'd0, mem_en}, {63'd0, dg || cg});
    if (dg || cg) begin
      chk("mem_we", {63'd0, mem_we}, {63'd0, dg ? dw : cw});
      chk("mem_addr", {57'd0, mem_addr}, {57'd0, dg ? da : ca});
      if (dg ? dw : cw) begin
        chk("mem_wdata", {32'd0, mem_wdata}, {32'd0, dg ? dd : cd});
        ref_mem[dg ? da : ca] = dg ? dd : cd;
      end else begin
        e.own = dg ? 2 : 1; e.data = ref_mem[dg ? da : ca]; e.due = cyc + 1;
        q.push_back(e);
      end
    end
    if (!dv || dg) ms = 0;
    else if (ms < LIM) ms++;
    tick();
  endtask

  task automatic idle();
    logic r;
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, r);
  endtask

  logic          rdy;
  logic [7:0]    a8;

  initial begin
    for (int i = 0; i < (1<<AW); i++) begin
      mem[i] = DW'(i);
      ref_mem[i] = DW'(i);
    end
    reset = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dma_valid = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
    @(posedge clk); #1;
    chk("rst_mem_en", {63'd0, mem_en}, 64'd0);
    @(posedge clk); #1;
    chk("rst_cpu_rv", {63'd0, cpu_rvalid}, 64'd0);
    chk("rst_dma_rv", {63'd0, dma_rvalid}, 64'd0);
    chk("rst_cpu_rd", {32'd0, cpu_rdata}, 64'd0);
    chk("rst_dma_rd", {32'd0, dma_rdata}, 64'd0);
    cpu_req = 1'b0;
    reset = 1'b0;

    // CPU-only read of preloaded address 5
    drive(1'b1, 1'b0, 7'd5, '0, 1'b0, 1'b0, '0, '0, rdy);
    idle();

    // DMA-only write then read back
    drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 7'd10, 32'hDEADBEEF, rdy);
    chk("dma_wr_ready", {63'd0, rdy}, 64'd1);
    drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 7'd10, '0, rdy);
    chk("dma_rd_ready", {63'd0, rdy}, 64'd1);
    idle();
    chk("dma_deadbeef", {32'd0, dma_rdata}, 64'h0000_0000_DEAD_BEEF);

    // Contention: DMA forced in through the starvation guard at cycles 4 and 9
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b0, 7'd20, '0, 1'b1, 1'b0, 7'd40, '0, rdy);
      chk($sformatf("contend_%0d", i), {63'd0, rdy}, {63'd0, (i == 4) || (i == 9)});
    end
    idle();

    // Back-to-back reads from different owners
    drive(1'b1, 1'b0, 7'd1, '0, 1'b0, 1'b0, '0, '0, rdy);
    drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 7'd2, '0, rdy);
    idle();
    chk("b2b_cpu", {32'd0, cpu_rdata}, 64'd1);
    chk("b2b_dma", {32'd0, dma_rdata}, 64'd2);

    // Back-to-back CPU writes and reads including a write-then-read
    drive(1'b1, 1'b1, 7'd33, 32'h1234_5678, 1'b0, 1'b0, '0, '0, rdy);
    drive(1'b1, 1'b0, 7'd33, '0, 1'b0, 1'b0, '0, '0, rdy);
    drive(1'b1, 1'b0, 7'd127, '0, 1'b0, 1'b0, '0, '0, rdy);
    idle();

    // Address wrap: 8-bit driver value 130 lands on word 2
    a8 = 8'd130;
    drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, a8[AW-1:0], 32'h0000_0055, rdy);
    drive(1'b1, 1'b0, 7'd2, '0, 1'b0, 1'b0, '0, '0, rdy);
    idle();
    chk("wrap_data", {32'd0, cpu_rdata}, 64'h55);

    // Reset the cycle after a CPU read grant: response dropped
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 7'd7;
    dma_valid = 1'b1; dma_we = 1'b0; dma_addr = 7'd9;
    #1;
    chk("pre_rst_grant", {63'd0, cpu_stall}, 64'd0);
    @(posedge clk); #1; cyc++;
    reset = 1'b1; cpu_req = 1'b0;
    #1;
    chk("rst_inflight_rv", {63'd0, cpu_rvalid}, 64'd0);
    chk("rst_mem_en_dma", {63'd0, mem_en}, 64'd0);
    chk("rst_dma_ready", {63'd0, dma_ready}, 64'd1);
    @(posedge clk); #1; cyc++;
    chk("rst2_cpu_rv", {63'd0, cpu_rvalid}, 64'd0);
    chk("rst2_cpu_rd", {32'd0, cpu_rdata}, 64'd0);
    chk("rst2_dma_rd", {32'd0, dma_rdata}, 64'd0);
    chk("rst2_state", {62'd0, 2'(dut.state_q)}, {62'd0, 2'(NONE)});
    chk("rst2_starve", {60'd0, dut.starve_cnt}, 64'd0);
    q.delete();
    last_cpu = '0; last_dma = '0; ms = 0;
    dma_valid = 1'b0;
    reset = 1'b0;
    idle();
    drive(1'b1, 1'b0, 7'd5, '0, 1'b0, 1'b0, '0, '0, rdy);
    idle();

    chk("q_empty", 64'(q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule
